ram: RTL and testbench



---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_if.sv | 34 +++
 rtl/ram_array.sv | 28 ++
 rtl/ram.sv | 93 +++++++++
 tb/tb_ram.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared widths and state encoding for the scratch RAM.
package ram_pkg;

  localparam int RAM_ADDR_WIDTH = 10;
  localparam int RAM_DATA_WIDTH = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_e;

endpackage

// File: rtl/ram_if.sv
// Access bus of the scratch RAM: address/data/command from the master, read data and ready flag back.
interface ram_if
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  write;
  logic                  select;
  logic                  init_done;

  modport master (
    output address,
    output data_in,
    output write,
    output select,
    input  data_out,
    input  init_done
  );

  modport slave (
    input  address,
    input  data_in,
    input  write,
    input  select,
    output data_out,
    output init_done
  );

endinterface

// File: rtl/ram_array.sv
// Plain single-port storage: one write port and a registered read port sharing one address.
module ram_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram.sv
// Scratch RAM top: post-reset clear sweep, then one user read or write per cycle.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic clk,
  input  logic rst,
  ram_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  ram_state_e            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic                  init_done_reg, init_done_next;
  logic                  rd_valid_reg, rd_valid_next;

  logic                  mem_we, mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= CLEAR;
      ptr_reg       <= '0;
      init_done_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      init_done_reg <= init_done_next;
      rd_valid_reg  <= rd_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    init_done_next = init_done_reg;
    rd_valid_next  = rd_valid_reg;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = bus.address;
    mem_wdata      = bus.data_in;
    case (state_reg)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_reg;
        mem_wdata = '0;
        ptr_next  = ptr_reg + ADDR_ONE;
        if (ptr_reg == LAST_ADDR) begin
          state_next     = READY;
          init_done_next = 1'b1;
        end
      end
      READY: begin
        if (bus.select) begin
          if (bus.write) begin
            mem_we = 1'b1;
          end else begin
            mem_re        = 1'b1;
            rd_valid_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  // The array has no reset, so gate it off while rst is high to leave contents untouched.
  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we & ~rst),
    .re   (mem_re & ~rst),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  // The read register survives reset; rd_valid_reg masks it to zero until the first read.
  assign bus.data_out  = rd_valid_reg ? mem_rdata : '0;
  assign bus.init_done = init_done_reg;

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the scratch RAM.
module tb_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;

  ram_if bus ();

  ram dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    bus.select  = 1'b1;
    bus.write   = 1'b1;
    bus.address = a;
    bus.data_in = d;
    tick();
    bus.select  = 1'b0;
    bus.write   = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a);
    bus.select  = 1'b1;
    bus.write   = 1'b0;
    bus.address = a;
    tick();
    bus.select  = 1'b0;
  endtask

  // Releases rst and counts edges until init_done; also flags any nonzero data_out seen meanwhile.
  task automatic wait_init(output int cycles, output logic saw_nonzero);
    cycles      = 0;
    saw_nonzero = 1'b0;
    rst         = 1'b0;
    while (bus.init_done !== 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
      if (bus.data_out !== 8'h00) saw_nonzero = 1'b1;
    end
  endtask

  logic [9:0] rd_addr [20] = '{10'd5, 10'd200, 10'd1023, 10'd0, 10'd1, 10'd127, 10'd128,
                               10'd129, 10'd255, 10'd256, 10'd300, 10'd511, 10'd512, 10'd640,
                               10'd700, 10'd777, 10'd900, 10'd1000, 10'd64, 10'd99};
  logic [7:0] rd_exp  [20] = '{8'd10, 8'd144, 8'd254, 8'd0, 8'd2, 8'd254, 8'd0,
                               8'd2, 8'd254, 8'd0, 8'd88, 8'd254, 8'd0, 8'd0,
                               8'd120, 8'd18, 8'd8, 8'd208, 8'd128, 8'd198};

  initial begin
    int   n;
    logic nz;

    bus.address = '0;
    bus.data_in = '0;
    bus.write   = 1'b0;
    bus.select  = 1'b0;

    // Reset state and clear sweep; a write issued during the sweep must be dropped.
    #1;
    check("reset_data_out", 32'(bus.data_out), 32'd0);
    check("reset_init_done", 32'(bus.init_done), 32'd0);
    tick(); tick();
    bus.select  = 1'b1;
    bus.write   = 1'b1;
    bus.address = 10'd0;
    bus.data_in = 8'hFF;
    wait_init(n, nz);
    bus.select  = 1'b0;
    bus.write   = 1'b0;
    check("sweep_cycles", 32'(n), 32'd1024);
    check("sweep_data_out_zero", 32'(nz), 32'd0);
    do_read(10'd0);    check("clear_rd_0", 32'(bus.data_out), 32'd0);
    do_read(10'd511);  check("clear_rd_511", 32'(bus.data_out), 32'd0);
    do_read(10'd1023); check("clear_rd_1023", 32'(bus.data_out), 32'd0);

    // Full fill with (2k) mod 256, then spot reads.
    for (int k = 0; k < 1024; k++) begin
      do_write(10'(k), 8'(2 * k));
    end
    for (int i = 0; i < 20; i++) begin
      do_read(rd_addr[i]);
      check($sformatf("fill_rd_%0d", rd_addr[i]), 32'(bus.data_out), 32'(rd_exp[i]));
    end

    // Deselected write must not land, and data_out must not move.
    do_write(10'd7, 8'hAA);
    bus.select  = 1'b0;
    bus.write   = 1'b1;
    bus.address = 10'd7;
    bus.data_in = 8'h55;
    tick();
    bus.write   = 1'b0;
    check("deselect_data_out_hold", 32'(bus.data_out), 32'd198);
    do_read(10'd7);
    check("deselect_rd_7", 32'(bus.data_out), 32'hAA);

    // Hold between reads.
    do_read(10'd3);
    check("hold_rd_3", 32'(bus.data_out), 32'd6);
    for (int c = 0; c < 5; c++) begin
      bus.address = 10'(c + 20);
      tick();
      check($sformatf("hold_cycle_%0d", c), 32'(bus.data_out), 32'd6);
    end

    // Back-to-back write then read of the same word.
    do_write(10'd10, 8'h3C);
    do_read(10'd10);
    check("b2b_rd_10", 32'(bus.data_out), 32'h3C);

    // Asynchronous reset after traffic clears data_out at once.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data_out", 32'(bus.data_out), 32'd0);
    check("async_rst_init_done", 32'(bus.init_done), 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    check("midsweep_init_done", 32'(bus.init_done), 32'd0);

    // Reset again mid-sweep; the sweep restarts from zero.
    #2;
    rst = 1'b1;
    tick();
    wait_init(n, nz);
    check("resweep_cycles", 32'(n), 32'd1024);
    check("resweep_data_out_zero", 32'(nz), 32'd0);
    do_read(10'd10);   check("resweep_rd_10", 32'(bus.data_out), 32'd0);
    do_read(10'd7);    check("resweep_rd_7", 32'(bus.data_out), 32'd0);
    do_read(10'd5);    check("resweep_rd_5", 32'(bus.data_out), 32'd0);
    do_read(10'd1023); check("resweep_rd_1023", 32'(bus.data_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
